// File: rtl/cnn_pkg.sv
// Shared CNN datapath defaults and the weight kernel loader state encoding.
package cnn_pkg;

  localparam int WEIGHT_WIDTH_DEF = 8;
  localparam int KERNEL_SIZE_DEF  = 9;
  localparam int IN_CH_NUM_DEF    = 64;
  localparam int OUT_CH_NUM_DEF   = 64;
  localparam int CH_W             = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RECV,
    FULL
  } wklState_e;

  // A single-entry bank still needs a one-bit index.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_kernel_loader_if.sv
// Request, weight-stream and kernel-delivery handshakes of the weight kernel loader.
interface weight_kernel_loader_if
  import cnn_pkg::*;
#(
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int KERNEL_SIZE  = KERNEL_SIZE_DEF
);

  logic                                req_valid;
  logic                                req_ready;
  logic [CH_W-1:0]                     req_in_ch;
  logic [CH_W-1:0]                     req_out_ch;

  logic                                mem_start;
  logic [CH_W-1:0]                     mem_in_ch;
  logic [CH_W-1:0]                     mem_out_ch;
  logic [WEIGHT_WIDTH-1:0]             mem_weight;
  logic                                mem_valid;
  logic                                mem_ready;

  logic [KERNEL_SIZE*WEIGHT_WIDTH-1:0] kernel_out;
  logic                                kernel_valid;
  logic                                kernel_ready;
  logic [CH_W-1:0]                     kernel_in_ch;
  logic [CH_W-1:0]                     kernel_out_ch;

  logic                                range_err;

  modport master (
    output req_valid, req_in_ch, req_out_ch, mem_weight, mem_valid, kernel_ready,
    input  req_ready, mem_start, mem_in_ch, mem_out_ch, mem_ready,
           kernel_out, kernel_valid, kernel_in_ch, kernel_out_ch, range_err
  );

  modport slave (
    input  req_valid, req_in_ch, req_out_ch, mem_weight, mem_valid, kernel_ready,
    output req_ready, mem_start, mem_in_ch, mem_out_ch, mem_ready,
           kernel_out, kernel_valid, kernel_in_ch, kernel_out_ch, range_err
  );

endinterface

// File: rtl/wkl_kernel_reg.sv
// Kernel register bank: one weight slot per kernel tap, written by index, bulk clearable.
module wkl_kernel_reg #(
  parameter int WEIGHT_WIDTH = 8,
  parameter int KERNEL_SIZE  = 9,
  parameter int IDX_W        = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear_i,
  input  logic                                wr_en_i,
  input  logic [IDX_W-1:0]                    wr_idx_i,
  input  logic [WEIGHT_WIDTH-1:0]             wr_data_i,
  output logic [KERNEL_SIZE*WEIGHT_WIDTH-1:0] kernel_o
);

  logic [KERNEL_SIZE-1:0][WEIGHT_WIDTH-1:0] bank_q;

  // Tap 0 lands in the least significant slot of the packed kernel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q <= '0;
    end else if (clear_i) begin
      bank_q <= '0;
    end else if (wr_en_i && (int'(wr_idx_i) < KERNEL_SIZE)) begin
      bank_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign kernel_o = bank_q;

endmodule

// File: rtl/weight_kernel_loader.sv
// Fetches one KERNEL_SIZE-weight kernel per request from the weight streamer and hands it on.
// Optional channel range checking: define WEIGHT_KERNEL_LOADER_RANGE_CHECK_EN.
module weight_kernel_loader
  import cnn_pkg::*;
#(
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int KERNEL_SIZE  = KERNEL_SIZE_DEF,
  parameter int IN_CH_NUM    = IN_CH_NUM_DEF,
  parameter int OUT_CH_NUM   = OUT_CH_NUM_DEF
) (
  input logic                  clk,
  input logic                  rst,
  weight_kernel_loader_if.slave bus
);

  localparam int               CNT_W     = idxWidth(KERNEL_SIZE);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(KERNEL_SIZE - 1);

  wklState_e        state_q, state_d;
  logic [CNT_W-1:0] beatCnt_q, beatCnt_d;
  logic [CH_W-1:0]  memInCh_q, memInCh_d;
  logic [CH_W-1:0]  memOutCh_q, memOutCh_d;
  logic [CH_W-1:0]  tagInCh_q, tagInCh_d;
  logic [CH_W-1:0]  tagOutCh_q, tagOutCh_d;

  logic reqReady, memStart, memReady, kernelValid;
  logic beatFire, kernelClear;
  logic reqInRange, reqBad;
  logic [KERNEL_SIZE*WEIGHT_WIDTH-1:0] kernelFlat;

  assign reqInRange = (int'(bus.req_in_ch) < IN_CH_NUM) && (int'(bus.req_out_ch) < OUT_CH_NUM);

`ifdef WEIGHT_KERNEL_LOADER_RANGE_CHECK_EN
  logic rangeErr_q;

  assign reqBad = !reqInRange;

  // A rejected request is still consumed in IDLE; the error is flagged the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rangeErr_q <= 1'b0;
    end else begin
      rangeErr_q <= (state_q == IDLE) && bus.req_valid && reqBad;
    end
  end

  assign bus.range_err = rangeErr_q;
`else
  logic unusedRangeOk;

  assign reqBad        = 1'b0;
  assign unusedRangeOk = reqInRange;
  assign bus.range_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beatCnt_q  <= '0;
      memInCh_q  <= '0;
      memOutCh_q <= '0;
      tagInCh_q  <= '0;
      tagOutCh_q <= '0;
    end else begin
      state_q    <= state_d;
      beatCnt_q  <= beatCnt_d;
      memInCh_q  <= memInCh_d;
      memOutCh_q <= memOutCh_d;
      tagInCh_q  <= tagInCh_d;
      tagOutCh_q <= tagOutCh_d;
    end
  end

  // Tags are copied only when the last beat lands so they always describe kernel_out.
  always_comb begin
    state_d     = state_q;
    beatCnt_d   = beatCnt_q;
    memInCh_d   = memInCh_q;
    memOutCh_d  = memOutCh_q;
    tagInCh_d   = tagInCh_q;
    tagOutCh_d  = tagOutCh_q;
    reqReady    = 1'b0;
    memStart    = 1'b0;
    memReady    = 1'b0;
    kernelValid = 1'b0;
    beatFire    = 1'b0;
    kernelClear = 1'b0;

    case (state_q)
      IDLE: begin
        reqReady = 1'b1;
        if (bus.req_valid && !reqBad) begin
          memInCh_d   = bus.req_in_ch;
          memOutCh_d  = bus.req_out_ch;
          beatCnt_d   = '0;
          kernelClear = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        memStart = 1'b1;
        state_d  = RECV;
      end
      RECV: begin
        memReady = 1'b1;
        if (bus.mem_valid) begin
          beatFire = 1'b1;
          if (beatCnt_q == LAST_BEAT) begin
            tagInCh_d  = memInCh_q;
            tagOutCh_d = memOutCh_q;
            state_d    = FULL;
          end else begin
            beatCnt_d = beatCnt_q + 1'b1;
          end
        end
      end
      FULL: begin
        kernelValid = 1'b1;
        if (bus.kernel_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  wkl_kernel_reg #(
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .KERNEL_SIZE  (KERNEL_SIZE),
    .IDX_W        (CNT_W)
  ) u_kernel_reg (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (kernelClear),
    .wr_en_i   (beatFire),
    .wr_idx_i  (beatCnt_q),
    .wr_data_i (bus.mem_weight),
    .kernel_o  (kernelFlat)
  );

  assign bus.req_ready     = reqReady;
  assign bus.mem_start     = memStart;
  assign bus.mem_ready     = memReady;
  assign bus.mem_in_ch     = memInCh_q;
  assign bus.mem_out_ch    = memOutCh_q;
  assign bus.kernel_valid  = kernelValid;
  assign bus.kernel_out    = kernelFlat;
  assign bus.kernel_in_ch  = tagInCh_q;
  assign bus.kernel_out_ch = tagOutCh_q;

endmodule

// File: tb/tb_weight_kernel_loader.sv
// Directed scoreboard bench for weight_kernel_loader; follows WEIGHT_KERNEL_LOADER_RANGE_CHECK_EN if defined.
module tb_weight_kernel_loader;

  typedef struct {
    logic [71:0] kernel;
    logic [7:0]  inCh;
    logic [7:0]  outCh;
    int          cycle;
  } expKernel_t;

  logic clk;
  logic rst;
  int   cycleCnt    = 0;
  int   compared    = 0;
  int   mismatched  = 0;
  int   rangeErrCnt = 0;
  logic kvPrev      = 1'b0;
  expKernel_t expQ[$];
  expKernel_t popped;

  weight_kernel_loader_if #(.WEIGHT_WIDTH(8), .KERNEL_SIZE(9)) bus ();

  weight_kernel_loader #(
    .WEIGHT_WIDTH (8),
    .KERNEL_SIZE  (9),
    .IN_CH_NUM    (64),
    .OUT_CH_NUM   (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every new kernel_valid is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.kernel_valid && !kvPrev) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_kernel: got kernel 0x%0h, expected none", bus.kernel_out);
      end else begin
        popped = expQ.pop_front();
        checkOutput("kernel_out", bus.kernel_out, popped.kernel);
        checkOutput("kernel_in_ch", bus.kernel_in_ch, popped.inCh);
        checkOutput("kernel_out_ch", bus.kernel_out_ch, popped.outCh);
        checkOutput("kernel_valid_cycle", cycleCnt, popped.cycle);
      end
    end
    kvPrev <= bus.kernel_valid;
    if (bus.range_err) rangeErrCnt <= rangeErrCnt + 1;
  end

  task automatic applyStimulus(input logic [7:0] inCh, input logic [7:0] outCh, output int hsCycle);
    bit done = 1'b0;
    hsCycle        = -1;
    bus.req_valid  = 1'b1;
    bus.req_in_ch  = inCh;
    bus.req_out_ch = outCh;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        done    = 1'b1;
        hsCycle = cycleCnt;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    checkOutput("req_accepted", done, 1'b1);
  endtask

  task automatic pushExpected(input logic [71:0] kernel, input logic [7:0] inCh, input logic [7:0] outCh,
                              input int cycle);
    expKernel_t e;
    e.kernel = kernel;
    e.inCh   = inCh;
    e.outCh  = outCh;
    e.cycle  = cycle;
    expQ.push_back(e);
  endtask

  // Streamer model: waits for mem_start, then offers base+k, optionally pausing before two beats.
  task automatic streamKernel(input logic [7:0] base, input logic [7:0] expIn, input logic [7:0] expOut,
                              input int stallA, input int stallB, input int stallLen, input int nBeats);
    int beat      = 0;
    int stallLeft = 0;
    int starts    = 0;
    bit started   = 1'b0;
    bit fire;
    for (int c = 0; c < 200 && beat < nBeats; c++) begin
      if (started && stallLeft == 0) begin
        bus.mem_valid  = 1'b1;
        bus.mem_weight = base + 8'(beat);
      end else begin
        bus.mem_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.mem_start) begin
        started = 1'b1;
        starts++;
        checkOutput("mem_in_ch", bus.mem_in_ch, expIn);
        checkOutput("mem_out_ch", bus.mem_out_ch, expOut);
      end
      fire = bus.mem_valid && bus.mem_ready;
      @(posedge clk);
      #1;
      if (stallLeft > 0) begin
        stallLeft--;
      end else if (fire) begin
        beat++;
        if (beat == stallA || beat == stallB) stallLeft = stallLen;
      end
    end
    bus.mem_valid = 1'b0;
    checkOutput("beats_accepted", beat, nBeats);
    checkOutput("mem_start_cycles", starts, 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    @(negedge clk);
    checkOutput({tag, "_req_ready"}, bus.req_ready, 1'b1);
    checkOutput({tag, "_mem_start"}, bus.mem_start, 1'b0);
    checkOutput({tag, "_mem_ready"}, bus.mem_ready, 1'b0);
    checkOutput({tag, "_kernel_valid"}, bus.kernel_valid, 1'b0);
    checkOutput({tag, "_range_err"}, bus.range_err, 1'b0);
    checkOutput({tag, "_kernel_out"}, bus.kernel_out, 72'h0);
    checkOutput({tag, "_kernel_tags"}, {bus.kernel_in_ch, bus.kernel_out_ch}, 16'h0);
    checkOutput({tag, "_mem_chs"}, {bus.mem_in_ch, bus.mem_out_ch}, 16'h0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hs;
    int rdyHigh, startHigh, kernChanged, kvLow, memRdyHigh;

    rst              = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_in_ch    = '0;
    bus.req_out_ch   = '0;
    bus.mem_weight   = '0;
    bus.mem_valid    = 1'b0;
    bus.kernel_ready = 1'b1;
    #2 rst = 1'b1;
    checkResetOutputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] plain load (3,5)");
    applyStimulus(8'd3, 8'd5, hs);
    pushExpected(72'h090807060504030201, 8'd3, 8'd5, hs + 11);
    streamKernel(8'h01, 8'd3, 8'd5, -1, -1, 0, 9);
    @(posedge clk);
    #1;

    $display("[TB] mem_valid while idle");
    bus.mem_valid  = 1'b1;
    bus.mem_weight = 8'hFF;
    memRdyHigh = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.mem_ready) memRdyHigh++;
      @(posedge clk);
      #1;
    end
    bus.mem_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle_mem_ready_cycles", memRdyHigh, 0);
    checkOutput("idle_kernel_out", bus.kernel_out, 72'h090807060504030201);
    @(posedge clk);
    #1;

    $display("[TB] stalled load (3,5)");
    applyStimulus(8'd3, 8'd5, hs);
    pushExpected(72'h090807060504030201, 8'd3, 8'd5, hs + 17);
    streamKernel(8'h01, 8'd3, 8'd5, 2, 6, 3, 9);
    @(posedge clk);
    #1;

    $display("[TB] kernel_ready held low");
    bus.kernel_ready = 1'b0;
    applyStimulus(8'd10, 8'd20, hs);
    pushExpected(72'hA9A8A7A6A5A4A3A2A1, 8'd10, 8'd20, hs + 11);
    streamKernel(8'hA1, 8'd10, 8'd20, -1, -1, 0, 9);
    bus.req_valid  = 1'b1;
    bus.req_in_ch  = 8'd7;
    bus.req_out_ch = 8'd7;
    rdyHigh = 0; startHigh = 0; kernChanged = 0; kvLow = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) rdyHigh++;
      if (bus.mem_start) startHigh++;
      if (bus.kernel_out !== 72'hA9A8A7A6A5A4A3A2A1) kernChanged++;
      if (!bus.kernel_valid) kvLow++;
      @(posedge clk);
      #1;
    end
    checkOutput("hold_req_ready_cycles", rdyHigh, 0);
    checkOutput("hold_mem_start_cycles", startHigh, 0);
    checkOutput("hold_kernel_changes", kernChanged, 0);
    checkOutput("hold_kernel_valid_drops", kvLow, 0);
    bus.kernel_ready = 1'b1;
    applyStimulus(8'd7, 8'd7, hs);
    pushExpected(72'h393837363534333231, 8'd7, 8'd7, hs + 11);
    streamKernel(8'h31, 8'd7, 8'd7, -1, -1, 0, 9);
    @(posedge clk);
    #1;

    $display("[TB] reset during receive");
    applyStimulus(8'd1, 8'd2, hs);
    streamKernel(8'h51, 8'd1, 8'd2, -1, -1, 0, 5);
    rst = 1'b1;
    checkResetOutputs("midrecv_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(8'd0, 8'd0, hs);
    pushExpected(72'h191817161514131211, 8'd0, 8'd0, hs + 11);
    streamKernel(8'h11, 8'd0, 8'd0, -1, -1, 0, 9);
    @(posedge clk);
    #1;

    $display("[TB] out-of-range request (64,0)");
    applyStimulus(8'd64, 8'd0, hs);
`ifdef WEIGHT_KERNEL_LOADER_RANGE_CHECK_EN
    @(negedge clk);
    checkOutput("range_err_pulse", bus.range_err, 1'b1);
    checkOutput("range_req_ready", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("range_err_cleared", bus.range_err, 1'b0);
    startHigh = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.mem_start) startHigh++;
      @(negedge clk);
    end
    checkOutput("range_mem_start_cycles", startHigh, 0);
    checkOutput("range_idle_req_ready", bus.req_ready, 1'b1);
`else
    pushExpected(72'h090807060504030201, 8'd64, 8'd0, hs + 11);
    streamKernel(8'h01, 8'd64, 8'd0, -1, -1, 0, 9);
`endif

    repeat (4) @(posedge clk);
    #1;
    checkOutput("pending_kernels", expQ.size(), 0);
`ifdef WEIGHT_KERNEL_LOADER_RANGE_CHECK_EN
    checkOutput("range_err_total", rangeErrCnt, 1);
`else
    checkOutput("range_err_total", rangeErrCnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/weight_kernel_loader.md
WEIGHT_KERNEL_LOADER -- requirements
Module: weight_kernel_loader

Interface
REQ-001 SHALL have parameter WEIGHT_WIDTH, default 8, bits per weight.
REQ-002 SHALL have parameter KERNEL_SIZE, default 9, weights per kernel (3x3).
REQ-003 SHALL have parameter IN_CH_NUM, default 64, input-channel count.
REQ-004 SHALL have parameter OUT_CH_NUM, default 64, output-channel count.
REQ-005 clk  input  1  clock; all logic rising-edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req_valid  input  1  controller requests a kernel.
REQ-008 req_ready  output  1  loader accepts a request.
REQ-009 req_in_ch / req_out_ch  input  8 each  requested channel pair.
REQ-010 mem_start  output  1  start pulse to the weight streamer.
REQ-011 mem_in_ch / mem_out_ch  output  8 each  channel pair to the streamer; stable while mem_start is high.
REQ-012 mem_weight  input  WEIGHT_WIDTH  streamed weight.
REQ-013 mem_valid  input  1  mem_weight valid.
REQ-014 mem_ready  output  1  loader accepts a weight beat.
REQ-015 kernel_out  output  KERNEL_SIZE*WEIGHT_WIDTH  packed kernel.
REQ-016 kernel_valid / kernel_ready  output / input  1 each  kernel handshake to the conv engine.
REQ-017 kernel_in_ch / kernel_out_ch  output  8 each  channel tag of kernel_out.
REQ-018 range_err  output  1  one-cycle pulse on a rejected request (REQ-034).

Function
REQ-019 FSM SHALL have states IDLE, START, RECV, FULL.
REQ-020 IDLE: req_ready=1; on req_valid&&req_ready, latch channel pair, clear beat counter, go START.
REQ-021 START: mem_start=1 for exactly one cycle, then go RECV unconditionally.
REQ-022 RECV: mem_ready=1; each mem_valid&&mem_ready beat k writes kernel_out[k*WEIGHT_WIDTH +: WEIGHT_WIDTH], beat 0 at LSB; counter increments.
REQ-023 Beat counter SHALL be $clog2(KERNEL_SIZE) bits; on beat KERNEL_SIZE-1, go FULL; no wrap beyond KERNEL_SIZE-1.
REQ-024 FULL: kernel_valid=1; kernel_out and tags stable; on kernel_ready go IDLE.
REQ-025 req_ready SHALL be 0 outside IDLE; requests during START/RECV/FULL are not accepted.
REQ-026 mem_ready SHALL be 0 outside RECV; mem_valid outside RECV is ignored, no register changes.
REQ-027 mem_valid gaps in RECV SHALL stall the counter without data loss.
REQ-028 Latency: with mem_valid continuously high from the cycle after mem_start, kernel_valid SHALL rise 11 cycles after the request-handshake cycle (KERNEL_SIZE=9).
REQ-029 kernel_ready low in FULL SHALL hold state indefinitely.

Reset
REQ-030 rst SHALL force IDLE, counter 0, and kernel_out, kernel_in_ch, kernel_out_ch, mem_in_ch, mem_out_ch to 0.
REQ-031 Outputs at reset: req_ready=1 (IDLE), mem_start=0, mem_ready=0, kernel_valid=0, range_err=0.
REQ-032 rst mid-RECV SHALL discard the partial kernel; no kernel_valid until a fresh full load completes.

Configuration
REQ-033 Macro WEIGHT_KERNEL_LOADER_RANGE_CHECK_EN SHALL gate channel range checking.
REQ-034 Defined: a request with req_in_ch>=IN_CH_NUM or req_out_ch>=OUT_CH_NUM SHALL be accepted, pulse range_err for one cycle, stay in IDLE, no mem_start.
REQ-035 Undefined: range_err tied 0; all requests forwarded unchanged.

Structure
REQ-036 Shared package cnn_pkg SHALL hold WEIGHT_WIDTH, KERNEL_SIZE, IN_CH_NUM, OUT_CH_NUM defaults and the loader state enum.
REQ-037 One sub-module wkl_kernel_reg SHALL implement the indexed write kernel register bank (write enable, index, data, clear).

Verification
REQ-038 Request (3,5), streamer beats 0x01..0x09 no stalls -> mem_start one cycle, kernel_out=0x090807060504030201, tags 3/5, kernel_valid 11 cycles after handshake.
REQ-039 Same load with mem_valid low on beats 2 and 6 for 3 cycles each -> identical kernel_out, kernel_valid delayed by 6 cycles.
REQ-040 kernel_ready held low 20 cycles in FULL, req_valid asserted -> req_ready=0, kernel_out stable, no mem_start; accepted only after kernel_ready.
REQ-041 rst pulsed after beat 4 -> all outputs reset values; next request (0,0) yields a clean full kernel.
REQ-042 Macro defined, request (64,0) -> range_err one pulse, no mem_start, state IDLE; macro undefined -> mem_start issued, range_err 0.
REQ-043 mem_valid asserted in IDLE with data 0xFF -> mem_ready=0, kernel_out unchanged.
